// File: rtl/ram_burst_controller_if.sv
// Burst request, write/read data streams and RAM port grouped into one bundle.
// The controller uses the slave view; the requester/RAM side uses the master view.
interface ram_burst_controller_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
);
  localparam int ADDR_WIDTH = $clog2(DEPTH);

  // Burst request
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [ADDR_WIDTH-1:0] req_len;
  logic [DATA_WIDTH-1:0] req_mask;

  // Write data stream
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wdata_valid;
  logic                  wdata_ready;

  // Read data stream (no backpressure)
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rdata_valid;
  logic                  rdata_last;

  // Burst completion pulse
  logic                  done;

  // RAM port
  logic                  ram_enable;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_data_in;
  logic [DATA_WIDTH-1:0] ram_write_mask;
  logic [DATA_WIDTH-1:0] ram_data_out;
  logic                  ram_busy;

  modport slave (
    input  req_valid, req_write, req_addr, req_len, req_mask,
    input  wdata, wdata_valid,
    input  ram_data_out, ram_busy,
    output req_ready, wdata_ready,
    output rdata, rdata_valid, rdata_last, done,
    output ram_enable, ram_we, ram_addr, ram_data_in, ram_write_mask
  );

  modport master (
    output req_valid, req_write, req_addr, req_len, req_mask,
    output wdata, wdata_valid,
    output ram_data_out, ram_busy,
    input  req_ready, wdata_ready,
    input  rdata, rdata_valid, rdata_last, done,
    input  ram_enable, ram_we, ram_addr, ram_data_in, ram_write_mask
  );
endinterface

// File: rtl/ram_burst_controller.sv
// Burst controller for a single-port RAM with one-cycle read latency.
// Accepts one burst request at a time, streams write beats from wdata (with a
// per-burst bit mask) or issues consecutive reads and returns them on rdata.
// Addresses wrap from DEPTH-1 to 0 within a burst.
module ram_burst_controller #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  ram_burst_controller_if.slave  bus
);
  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Burst direction is carried by the state itself (WRITE vs READ).
  state_t                state_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;        // address of the next beat
  logic [ADDR_WIDTH-1:0] len_reg;         // latched burst length minus one
  logic [ADDR_WIDTH-1:0] count_reg;       // beats issued so far
  logic [DATA_WIDTH-1:0] mask_reg;        // latched write mask
  logic [ADDR_WIDTH-1:0] hold_addr_reg;   // ram_addr shown between beats
  logic                  rdata_valid_reg;
  logic                  rdata_last_reg;
  logic                  done_reg;

  logic                  write_beat;
  logic                  read_issue;
  logic                  any_beat;
  logic                  last_beat;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic [DATA_WIDTH-1:0] data_in_gated;
  logic [DATA_WIDTH-1:0] mask_gated;
  logic [DATA_WIDTH-1:0] rdata_gated;

  // A write beat needs data and a free RAM; a read issues whenever the RAM is free.
  assign write_beat = (state_reg == WRITE) && bus.wdata_valid && !bus.ram_busy;
  assign read_issue = (state_reg == READ) && !bus.ram_busy;
  assign any_beat   = write_beat || read_issue;
  assign last_beat  = (count_reg == len_reg);

  // Wrap explicitly so non-power-of-two depths stay inside the array.
  assign addr_next = (addr_reg == LAST_ADDR) ? '0 : addr_reg + ADDR_WIDTH'(1);

  // Per-bit gating: RAM data/mask only carry values during a write beat, and
  // the pass-through read data is forced to zero outside rdata_valid so the
  // stream is quiet after reset and between beats.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_bit
      assign data_in_gated[gi] = write_beat & bus.wdata[gi];
      assign mask_gated[gi]    = write_beat & mask_reg[gi];
      assign rdata_gated[gi]   = rdata_valid_reg & bus.ram_data_out[gi];
    end
  endgenerate

  // Handshake and RAM strobes; strobes must coincide with the beat itself.
  assign bus.req_ready      = (state_reg == IDLE);
  assign bus.wdata_ready    = (state_reg == WRITE) && !bus.ram_busy;
  assign bus.ram_enable     = any_beat;
  assign bus.ram_we         = write_beat;
  assign bus.ram_addr       = any_beat ? addr_reg : hold_addr_reg;
  assign bus.ram_data_in    = data_in_gated;
  assign bus.ram_write_mask = mask_gated;

  // Read data arrives from the RAM one cycle after the issue; only the
  // qualifiers are registered, the data itself is passed straight through.
  assign bus.rdata       = rdata_gated;
  assign bus.rdata_valid = rdata_valid_reg;
  assign bus.rdata_last  = rdata_last_reg;
  assign bus.done        = done_reg;

  // Burst sequencing: latch the request, step address and beat count, and
  // raise the one-cycle read/done qualifiers for the cycle after each beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      addr_reg        <= '0;
      len_reg         <= '0;
      count_reg       <= '0;
      mask_reg        <= '0;
      hold_addr_reg   <= '0;
      rdata_valid_reg <= 1'b0;
      rdata_last_reg  <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      rdata_valid_reg <= 1'b0;
      rdata_last_reg  <= 1'b0;
      done_reg        <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (bus.req_valid) begin
            addr_reg  <= bus.req_addr;
            len_reg   <= bus.req_len;
            mask_reg  <= bus.req_mask;
            count_reg <= '0;
            state_reg <= bus.req_write ? WRITE : READ;
          end
        end

        WRITE: begin
          if (write_beat) begin
            hold_addr_reg <= addr_reg;
            addr_reg      <= addr_next;
            count_reg     <= count_reg + ADDR_WIDTH'(1);
            if (last_beat) begin
              done_reg  <= 1'b1;
              state_reg <= IDLE;
            end
          end
        end

        READ: begin
          if (read_issue) begin
            hold_addr_reg   <= addr_reg;
            addr_reg        <= addr_next;
            count_reg       <= count_reg + ADDR_WIDTH'(1);
            rdata_valid_reg <= 1'b1;
            rdata_last_reg  <= last_beat;
            if (last_beat) begin
              done_reg  <= 1'b1;
              state_reg <= DRAIN;
            end
          end
        end

        DRAIN: begin
          // Final read data is on the bus this cycle; nothing new may start.
          state_reg <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_burst_controller.sv
// Randomized bench for ram_burst_controller: a behavioural RAM answers the
// controller's strobes, and a shadow memory predicts every beat, read value
// and completion timing from the burst rules.
module tb_ram_burst_controller;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic clk;
  logic rst;
  logic ram_load;

  int total;
  int bad;
  int cyc;
  bit mon_on;
  int busy_viol;

  // Monitor records, one entry per observed event
  int s_addr[$];
  int s_we[$];
  int s_din[$];
  int s_mask[$];
  int s_cyc[$];
  int r_data[$];
  int r_last[$];
  int r_cyc[$];
  int d_cyc[$];
  int a_cyc[$];

  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] ram_mem   [DEPTH];

  ram_burst_controller_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  ram_burst_controller #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: masked write, one-cycle registered read.
  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < DEPTH; i++) ram_mem[i] <= model_mem[i];
    end else if (bus.ram_enable) begin
      if (bus.ram_we)
        ram_mem[bus.ram_addr] <= (ram_mem[bus.ram_addr] & ~bus.ram_write_mask) |
                                 (bus.ram_data_in & bus.ram_write_mask);
      else
        bus.ram_data_out <= ram_mem[bus.ram_addr];
    end
  end

  // Observe the bus mid-cycle and log strobes, read returns, done and accepts.
  always @(negedge clk) begin
    if (mon_on) begin
      if (bus.ram_enable) begin
        s_addr.push_back(int'(bus.ram_addr));
        s_we.push_back(int'(bus.ram_we));
        s_din.push_back(int'(bus.ram_data_in));
        s_mask.push_back(int'(bus.ram_write_mask));
        s_cyc.push_back(cyc);
        if (bus.ram_busy) busy_viol++;
      end
      if (bus.ram_we && !bus.ram_enable) busy_viol++;
      if (bus.rdata_valid) begin
        r_data.push_back(int'(bus.rdata));
        r_last.push_back(int'(bus.rdata_last));
        r_cyc.push_back(cyc);
      end
      if (bus.done) d_cyc.push_back(cyc);
      if (bus.req_valid && bus.req_ready) a_cyc.push_back(cyc);
    end
    cyc++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clear_mon();
    s_addr.delete(); s_we.delete(); s_din.delete(); s_mask.delete(); s_cyc.delete();
    r_data.delete(); r_last.delete(); r_cyc.delete(); d_cyc.delete(); a_cyc.delete();
    busy_viol = 0;
  endtask

  // One burst from request to completion, then compare every logged event
  // against what the burst rules predict. Called at posedge+1, returns there.
  task automatic run_burst(input bit wr, input int addr, input int len,
                           input logic [DW-1:0] mask, input int busy_pct,
                           input logic [31:0] busy_pat, input int valid_pct,
                           input bit hold_req, input bit use_const,
                           input logic [DW-1:0] const_val);
    logic [DW-1:0] wq[$];
    logic [DW-1:0] wd[$];
    int  n;
    int  k;
    int  a;
    bit  got_done;
    bit  busy_now;
    bit  no_stall;
    logic [DW-1:0] v;

    n = len + 1;
    for (int i = 0; i < n; i++) begin
      v = use_const ? const_val : DW'($urandom);
      wq.push_back(v);
      wd.push_back(v);
    end
    clear_mon();
    mon_on = 1'b1;

    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = 4'(addr);
    bus.req_len   = 4'(len);
    bus.req_mask  = mask;
    @(negedge clk);
    check("req_ready_idle", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    if (hold_req) begin
      bus.req_write = !wr;
      bus.req_addr  = 4'($urandom);
    end

    k = 0;
    got_done = 1'b0;
    while (!got_done && k < 400) begin
      busy_now = (k < 32 && busy_pat[k]) || (int'($urandom_range(0, 99)) < busy_pct);
      bus.ram_busy = busy_now;
      if (wr) begin
        bus.wdata_valid = (wq.size() > 0) && (int'($urandom_range(0, 99)) < valid_pct);
        bus.wdata       = (wq.size() > 0) ? wq[0] : DW'($urandom);
      end
      bus.req_valid = hold_req && wr && (wq.size() > 0);
      @(negedge clk);
      if (wr && wq.size() > 0)
        check("wdata_ready", 32'(bus.wdata_ready), 32'(!busy_now));
      if (bus.req_valid)
        check("req_ready_busy", 32'(bus.req_ready), 32'd0);
      if (bus.wdata_valid && bus.wdata_ready && wq.size() > 0) void'(wq.pop_front());
      if (bus.done) begin
        got_done = 1'b1;
        check("req_ready_at_done", 32'(bus.req_ready), 32'(wr));
      end
      @(posedge clk); #1;
      k++;
    end
    bus.req_valid   = 1'b0;
    bus.ram_busy    = 1'b0;
    bus.wdata_valid = 1'b0;
    check("done_seen", 32'(got_done), 32'd1);
    @(negedge clk);
    check("req_ready_after", 32'(bus.req_ready), 32'd1);
    check("idle_no_strobe", 32'(bus.ram_enable), 32'd0);
    mon_on = 1'b0;

    check("beats", 32'(s_addr.size()), 32'(n));
    for (int i = 0; i < n && i < s_addr.size(); i++) begin
      a = (addr + i) % DEPTH;
      check("ram_addr", 32'(s_addr[i]), 32'(a));
      check("ram_we", 32'(s_we[i]), 32'(wr));
      check("ram_mask", 32'(s_mask[i]), wr ? 32'(mask) : 32'd0);
      if (wr) check("ram_data_in", 32'(s_din[i]), 32'(wd[i]));
    end
    check("strobe_rule", 32'(busy_viol), 32'd0);
    check("accepts", 32'(a_cyc.size()), 32'd1);

    no_stall = (busy_pct == 0) && (busy_pat == 0) && (!wr || valid_pct == 100);
    if (no_stall && s_cyc.size() == n && a_cyc.size() == 1) begin
      check("first_beat_lat", 32'(s_cyc[0]), 32'(a_cyc[0] + 1));
      for (int i = 1; i < n; i++)
        check("back_to_back", 32'(s_cyc[i]), 32'(s_cyc[0] + i));
    end

    check("done_count", 32'(d_cyc.size()), 32'd1);
    if (d_cyc.size() == 1 && s_cyc.size() == n)
      check("done_lat", 32'(d_cyc[0]), 32'(s_cyc[n-1] + 1));

    if (wr) begin
      check("rvalid_on_write", 32'(r_data.size()), 32'd0);
      for (int i = 0; i < n; i++) begin
        a = (addr + i) % DEPTH;
        model_mem[a] = (model_mem[a] & ~mask) | (wd[i] & mask);
      end
    end else begin
      check("reads", 32'(r_data.size()), 32'(n));
      for (int i = 0; i < n && i < r_data.size(); i++) begin
        a = (addr + i) % DEPTH;
        check("rdata", 32'(r_data[i]), 32'(model_mem[a]));
        check("rdata_last", 32'(r_last[i]), 32'(i == n - 1));
        if (i < s_cyc.size())
          check("read_lat", 32'(r_cyc[i]), 32'(s_cyc[i] + 1));
      end
    end

    $display("burst %s addr=%0d len=%0d mask=%02h beats=%0d reads=%0d",
             wr ? "write" : "read ", addr, len, mask, s_addr.size(), r_data.size());
    @(posedge clk); #1;
  endtask

  // Read burst of 8 beats, reset asserted during the third issue.
  task automatic reset_mid_read();
    clear_mon();
    mon_on = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 4'd0;
    bus.req_len   = 4'd7;
    bus.req_mask  = 8'hFF;
    bus.ram_busy  = 1'b0;
    @(posedge clk); #1;            // beat 0 cycle
    bus.req_valid = 1'b0;
    @(posedge clk); #1;            // beat 1 cycle
    @(posedge clk); #1;            // beat 2 cycle
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_rdata_valid", 32'(bus.rdata_valid), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_enable", 32'(bus.ram_enable), 32'd0);
    check("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
    repeat (8) @(negedge clk);
    mon_on = 1'b0;
    check("rst_issues", 32'(s_addr.size()), 32'd3);
    check("rst_reads", 32'(r_data.size()), 32'd2);
    check("rst_no_done", 32'(d_cyc.size()), 32'd0);
    $display("burst read  addr=0 len=7 reset after beat 2 issues=%0d reads=%0d",
             s_addr.size(), r_data.size());
    @(posedge clk); #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    mon_on = 1'b0;
    busy_viol = 0;
    rst = 1'b1;
    ram_load = 1'b1;
    bus.req_valid   = 1'b0;
    bus.req_write   = 1'b0;
    bus.req_addr    = '0;
    bus.req_len     = '0;
    bus.req_mask    = '0;
    bus.wdata       = '0;
    bus.wdata_valid = 1'b0;
    bus.ram_busy    = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = DW'($urandom);

    repeat (3) @(posedge clk);
    #1;
    ram_load = 1'b0;
    @(negedge clk);
    check("reset_req_ready", 32'(bus.req_ready), 32'd1);
    check("reset_enable", 32'(bus.ram_enable), 32'd0);
    check("reset_we", 32'(bus.ram_we), 32'd0);
    check("reset_wdata_ready", 32'(bus.wdata_ready), 32'd0);
    check("reset_rdata_valid", 32'(bus.rdata_valid), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_ram_addr", 32'(bus.ram_addr), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed bursts
    run_burst(1'b1, 5, 0, 8'hFF, 0, 32'd0, 100, 1'b0, 1'b1, 8'hAA);
    run_burst(1'b1, 0, 4, 8'hFF, 0, 32'd0, 100, 1'b0, 1'b1, 8'hFF);
    run_burst(1'b0, 0, 4, 8'hFF, 0, 32'd0, 100, 1'b0, 1'b0, 8'h00);
    run_burst(1'b0, 14, 3, 8'hFF, 0, 32'd0, 100, 1'b0, 1'b0, 8'h00);
    run_burst(1'b1, 3, 2, 8'hFF, 0, 32'b1110, 100, 1'b0, 1'b0, 8'h00);
    run_burst(1'b1, 7, 3, 8'h0F, 0, 32'd0, 100, 1'b1, 1'b0, 8'h00);
    run_burst(1'b0, 7, 3, 8'hFF, 0, 32'd0, 100, 1'b0, 1'b0, 8'h00);
    run_burst(1'b1, 9, 15, 8'hFF, 0, 32'd0, 100, 1'b0, 1'b0, 8'h00);
    run_burst(1'b0, 9, 15, 8'hFF, 0, 32'd0, 100, 1'b0, 1'b0, 8'h00);
    reset_mid_read();

    // Randomized bursts with stalls and data gaps
    for (int t = 0; t < 30; t++) begin
      run_burst(1'($urandom), int'($urandom_range(0, DEPTH - 1)),
                int'($urandom_range(0, DEPTH - 1)), DW'($urandom),
                25, 32'd0, 70, 1'b0, 1'b0, 8'h00);
    end
    // Final full read-back of the whole array
    run_burst(1'b0, 0, DEPTH - 1, 8'hFF, 20, 32'd0, 100, 1'b0, 1'b0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
